if_stage: RTL and testbench

Parametrised instruction-fetch stage for the pipelined MIPS core. It holds the program counter and selects the next PC from pc+4, a taken branch, a J-type jump or a `jr` register target. It drives the instruction-memory address and registers the fetched instruction into the IF/ID pipeline register. It also honours stall and flush requests from the hazard unit and keeps a saturating count of retired fetches.

---
 rtl/if_stage.sv | 89 ++++++++
 tb/tb_if_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, picks the next PC (jr > jump > branch > pc+4),
// and registers the fetched word into IF/ID with stall, flush and redirect handling.
module if_stage #(
    parameter int unsigned           XLEN     = 32,
    parameter logic [XLEN-1:0]       RESET_PC = '0,
    parameter int unsigned           CNT_W    = 16,
    parameter logic [31:0]           NOP      = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [XLEN-1:0]  jr_target,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ifid_instr,
    output logic [XLEN-1:0]  ifid_pc_plus_4,
    output logic             ifid_valid,
    output logic             misalign,
    output logic [CNT_W-1:0] fetch_count
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect;
    logic            target_misaligned;
    logic            count_full;

    assign imem_addr   = pc;
    assign pc_plus_4   = pc + XLEN'(4);
    assign jump_target = {ifid_pc_plus_4[XLEN-1:28], jump_index, 2'b00};
    assign redirect    = jr | jump | branch_taken;
    assign count_full  = (fetch_count == {CNT_W{1'b1}});

    always_comb begin
        raw_target = pc_plus_4;
        if (jr)
            raw_target = jr_target;
        else if (jump)
            raw_target = jump_target;
        else if (branch_taken)
            raw_target = branch_target;
    end

    // Targets are word-aligned by dropping the low bits; the dropped bits flag misalign.
    assign redirect_pc       = {raw_target[XLEN-1:2], 2'b00};
    assign target_misaligned = redirect & (raw_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            ifid_instr     <= NOP;
            ifid_pc_plus_4 <= '0;
            ifid_valid     <= 1'b0;
            fetch_count    <= '0;
            misalign       <= 1'b0;
        end else begin
            misalign <= target_misaligned;
            if (redirect) begin
                pc             <= redirect_pc;
                ifid_instr     <= NOP;
                ifid_pc_plus_4 <= '0;
                ifid_valid     <= 1'b0;
            end else if (flush) begin
                ifid_instr     <= NOP;
                ifid_pc_plus_4 <= '0;
                ifid_valid     <= 1'b0;
                if (!stall)
                    pc <= pc_plus_4;
            end else if (!stall) begin
                pc             <= pc_plus_4;
                ifid_instr     <= imem_rdata;
                ifid_pc_plus_4 <= pc_plus_4;
                ifid_valid     <= 1'b1;
                if (!count_full)
                    fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random traffic, each cycle checked against
// a behavioural model of the fetch rules and a synthetic instruction memory.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOPW   = 32'h0000_0000;
    localparam int          CW     = 4;

    logic          clk = 1'b0;
    logic          rst_n, stall, flush, branch_taken, jump, jr;
    logic [31:0]   branch_target, jr_target, imem_addr, imem_rdata;
    logic [25:0]   jump_index;
    logic [31:0]   ifid_instr, ifid_pc_plus_4;
    logic          ifid_valid, misalign;
    logic [CW-1:0] fetch_count;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid, m_mis;
    int          m_cnt;

    if_stage #(.XLEN(32), .RESET_PC(RST_PC), .CNT_W(CW), .NOP(NOPW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ifid_instr(ifid_instr), .ifid_pc_plus_4(ifid_pc_plus_4),
        .ifid_valid(ifid_valid), .misalign(misalign), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic bubble();
        m_instr = NOPW;
        m_pp4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        logic        redir;
        if (!rst_n) begin
            m_pc = RST_PC; bubble(); m_cnt = 0; m_mis = 1'b0;
        end else begin
            redir = jr || jump || branch_taken;
            tgt   = jr ? jr_target : jump ? {m_pp4[31:28], jump_index, 2'b00} : branch_target;
            m_mis = redir && (tgt % 4 != 0);
            if (redir) begin
                m_pc = tgt - (tgt % 4);
                bubble();
            end else if (!stall) begin
                if (flush) bubble();
                else begin
                    m_instr = mem_word(m_pc);
                    m_pp4   = m_pc + 4;
                    m_valid = 1'b1;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                end
                m_pc = m_pc + 4;
            end else if (flush) begin
                bubble();
            end
        end
    endtask

    // one clock: model advances with the inputs sampled at the edge, outputs checked #1 later
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("pc",       imem_addr,      m_pc);
        check("instr",    ifid_instr,     m_instr);
        check("pp4",      ifid_pc_plus_4, m_pp4);
        check("valid",    ifid_valid,     m_valid);
        check("misalign", misalign,       m_mis);
        check("count",    fetch_count,    m_cnt);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; branch_taken = 0; jump = 0; jr = 0;
        branch_target = 0; jr_target = 0; jump_index = 0;
    endtask

    initial begin
        logic [31:0] pc_s, instr_s;
        logic [CW-1:0] cnt_s;

        idle_inputs();
        rst_n = 0;
        m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
        #2;
        cycle(); cycle();
        check("rst_pc", imem_addr, RST_PC);
        check("rst_valid", ifid_valid, 1'b0);
        check("rst_count", fetch_count, 0);

        // sequential fetch after reset release
        rst_n = 1;
        cycle();
        check("seq_pc1", imem_addr, 32'h0040_0004);
        check("seq_valid", ifid_valid, 1'b1);
        check("seq_instr", ifid_instr, mem_word(32'h0040_0000));
        cycle(); cycle();
        check("seq_pc3", imem_addr, 32'h0040_000C);
        check("seq_count3", fetch_count, 3);

        // stall for 3 cycles
        pc_s = imem_addr; instr_s = ifid_instr; cnt_s = fetch_count;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_pc", imem_addr, pc_s);
            check("stall_instr", ifid_instr, instr_s);
            check("stall_count", fetch_count, cnt_s);
        end
        stall = 0;
        cycle();
        check("resume_instr", ifid_instr, mem_word(pc_s));
        check("resume_pp4", ifid_pc_plus_4, pc_s + 4);

        // all three redirects at once: jr wins
        jr = 1; jr_target = 32'h0000_1000; jump = 1; jump_index = 26'h155;
        branch_taken = 1; branch_target = 32'h0000_5000;
        cycle();
        check("prio_jr_pc", imem_addr, 32'h0000_1000);
        check("prio_jr_valid", ifid_valid, 1'b0);
        idle_inputs();

        // set up ifid_pc_plus_4 = 0x3000_0010, then jump beats branch
        jr = 1; jr_target = 32'h3000_000C;
        cycle();
        idle_inputs();
        cycle();
        check("prio_pp4", ifid_pc_plus_4, 32'h3000_0010);
        jump = 1; jump_index = 26'h40; branch_taken = 1; branch_target = 32'h0000_7000;
        cycle();
        check("prio_jump_pc", imem_addr, 32'h3000_0100);
        idle_inputs();

        // misaligned branch during stall
        stall = 1; branch_taken = 1; branch_target = 32'h0000_2002;
        cycle();
        check("mis_pc", imem_addr, 32'h0000_2000);
        check("mis_pulse", misalign, 1'b1);
        check("mis_valid", ifid_valid, 1'b0);
        idle_inputs();
        cycle();
        check("mis_clear", misalign, 1'b0);
        check("redir_target_instr", ifid_instr, mem_word(32'h0000_2000));

        // flush at the top of the address space
        jr = 1; jr_target = 32'hFFFF_FFFC;
        cycle();
        idle_inputs();
        cnt_s = fetch_count;
        flush = 1;
        cycle();
        check("wrap_pc", imem_addr, 32'h0000_0000);
        check("wrap_instr", ifid_instr, NOPW);
        check("wrap_valid", ifid_valid, 1'b0);
        check("wrap_count", fetch_count, cnt_s);
        flush = 0;

        // counter saturation
        for (int i = 0; i < 20; i++) cycle();
        check("sat_count", fetch_count, 15);
        cycle();
        check("sat_hold", fetch_count, 15);

        // reset during a redirect
        rst_n = 0; jr = 1; jr_target = 32'h0000_8003;
        cycle();
        check("mid_rst_pc", imem_addr, RST_PC);
        check("mid_rst_instr", ifid_instr, NOPW);
        check("mid_rst_pp4", ifid_pc_plus_4, 32'h0);
        check("mid_rst_valid", ifid_valid, 1'b0);
        check("mid_rst_mis", misalign, 1'b0);
        check("mid_rst_count", fetch_count, 0);
        idle_inputs();
        rst_n = 1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            stall         = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            jr            = ($urandom_range(0, 19) == 0);
            jump          = ($urandom_range(0, 14) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            jr_target     = $urandom;
            branch_target = $urandom;
            jump_index    = 26'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
